// File: rtl/pa_mem_responder.sv
// pa_mem_responder: memory-side responder for fetch, data-read and data-write
// channels; serves one request at a time after a programmable latency.
module pa_mem_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h1000,
    parameter int unsigned LATENCY   = 2,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [32:0] if_req_i,
    output logic [32:0] if_resp_o,
    input  logic [32:0] rd_req_i,
    output logic [32:0] rd_resp_o,
    input  logic [64:0] wr_req_i,
    output logic        wr_resp_o,
    output logic        oob_o
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {CH_IF, CH_RD, CH_WR} chan_t;

    state_t state_q, state_d;
    chan_t  ch_q, win_ch, cur_ch;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [31:0] win_addr, win_data, cur_addr, cur_data, off;
    logic [3:0]  cnt_q;
    logic        oob_q, any_req, acc, go_resp, cur_ok;
    logic        in_resp, v_if, v_rd;
    logic [AW-1:0] idx;
    logic        unused_lo;
    logic [31:0] mem [MEM_WORDS];

    assign any_req = if_req_i[32] | rd_req_i[32] | wr_req_i[64];
    assign acc     = (state_q == S_IDLE) && any_req;

    // Fixed-priority winner: write, then read, then fetch.
    always_comb begin
        win_ch   = CH_IF;
        win_addr = if_req_i[31:0];
        win_data = 32'h0;
        if (wr_req_i[64]) begin
            win_ch   = CH_WR;
            win_addr = wr_req_i[63:32];
            win_data = wr_req_i[31:0];
        end else if (rd_req_i[32]) begin
            win_ch   = CH_RD;
            win_addr = rd_req_i[31:0];
        end
    end

    // Next state: IDLE -> WAIT -> RESP -> IDLE, WAIT skipped when LATENCY is 1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = (LATENCY <= 1) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q <= 4'd1) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // On the edge into RESP the transaction may still be on the live inputs.
    assign cur_ch   = acc ? win_ch   : ch_q;
    assign cur_addr = acc ? win_addr : addr_q;
    assign cur_data = acc ? win_data : wdata_q;
    assign off      = cur_addr - BASE_ADDR;
    assign idx      = off[AW+1:2];
    assign cur_ok   = (cur_addr >= BASE_ADDR) &&
                      ({2'b00, off[31:2]} < MEM_WORDS);
    assign go_resp  = rstn_i && (state_d == S_RESP);
    assign unused_lo = ^off[1:0];

    // Control state, latched transaction and latency counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            ch_q    <= CH_IF;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 4'd0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            oob_q   <= go_resp && !cur_ok;
            if (acc) begin
                ch_q    <= win_ch;
                addr_q  <= win_addr;
                wdata_q <= win_data;
                cnt_q   <= CNT_INIT;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Array access happens once, on the edge entering RESP.
    always_ff @(posedge clk_i) begin
        if (go_resp) begin
            if (cur_ch == CH_WR && cur_ok) mem[idx] <= cur_data;
            rdata_q <= cur_ok ? mem[idx] : 32'h0;
        end
    end

    assign in_resp   = (state_q == S_RESP);
    assign v_if      = in_resp && (ch_q == CH_IF);
    assign v_rd      = in_resp && (ch_q == CH_RD);
    assign if_resp_o = {v_if, v_if ? rdata_q : 32'h0};
    assign rd_resp_o = {v_rd, v_rd ? rdata_q : 32'h0};
    assign wr_resp_o = in_resp && (ch_q == CH_WR);
    assign oob_o     = in_resp && oob_q;

endmodule

// File: tb/tb_pa_mem_responder.sv
// tb_pa_mem_responder: randomized scoreboard bench for pa_mem_responder,
// plus a LATENCY=1 instance for back-to-back throughput.
module tb_pa_mem_responder;

    localparam int MW  = 64;
    localparam int LAT = 2;
    localparam logic [31:0] BASE = 32'h1000;

    typedef struct {
        int          cyc;
        int          ch;
        logic [31:0] data;
        logic        oob;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    logic [32:0] if_req = '0, rd_req = '0;
    logic [64:0] wr_req = '0;
    logic [32:0] if_resp, rd_resp;
    logic        wr_resp, oob;

    logic [32:0] if_req1 = '0, rd_req1 = '0;
    logic [64:0] wr_req1 = '0;
    logic [32:0] if_resp1, rd_resp1;
    logic        wr_resp1, oob1;

    exp_t        sbq[$];
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pa_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
        .clk_i(clk), .rstn_i(rstn),
        .if_req_i(if_req), .if_resp_o(if_resp),
        .rd_req_i(rd_req), .rd_resp_o(rd_resp),
        .wr_req_i(wr_req), .wr_resp_o(wr_resp),
        .oob_o(oob)
    );

    pa_mem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rstn_i(rstn),
        .if_req_i(if_req1), .if_resp_o(if_resp1),
        .rd_req_i(rd_req1), .rd_resp_o(rd_resp1),
        .wr_req_i(wr_req1), .wr_resp_o(wr_resp1),
        .oob_o(oob1)
    );

    function automatic logic is_oob(input logic [31:0] a);
        return (a < BASE) || (((a - BASE) >> 2) >= MW);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'($urandom_range(0, 32'h0FFF));
        if (r == 1) return BASE + 32'(4 * MW) + 32'($urandom_range(0, 64));
        return BASE + 32'(4 * $urandom_range(0, MW - 1)) + 32'($urandom_range(0, 3));
    endfunction

    // Called at a negedge with the DUT idle; mask bit2=wr, bit1=rd, bit0=fetch.
    task automatic run_batch(input logic [2:0] mask, input logic [31:0] fa,
                             input logic [31:0] ra, input logic [31:0] wa,
                             input logic [31:0] wd, input int gap);
        int e, k, last;
        int rc[3];
        logic [31:0] d;
        e = cyc + 1;
        k = 0;
        rc = '{-1, -1, -1};
        if (mask[2]) begin
            rc[2] = e + k * (LAT + 1) + LAT - 1;
            k++;
            if (!is_oob(wa)) mdl[widx(wa)] = wd;
            sbq.push_back('{rc[2], 2, 32'h0, is_oob(wa)});
        end
        if (mask[1]) begin
            rc[1] = e + k * (LAT + 1) + LAT - 1;
            k++;
            d = is_oob(ra) ? 32'h0 : mdl[widx(ra)];
            sbq.push_back('{rc[1], 1, d, is_oob(ra)});
        end
        if (mask[0]) begin
            rc[0] = e + k * (LAT + 1) + LAT - 1;
            k++;
            d = is_oob(fa) ? 32'h0 : mdl[widx(fa)];
            sbq.push_back('{rc[0], 0, d, is_oob(fa)});
        end
        last = e + (k - 1) * (LAT + 1) + LAT - 1;
        if_req = {mask[0], fa};
        rd_req = {mask[1], ra};
        wr_req = {mask[2], wa, wd};
        while (cyc < last) begin
            @(negedge clk);
            if (cyc == rc[0]) if_req[32] = 1'b0;
            if (cyc == rc[1]) rd_req[32] = 1'b0;
            if (cyc == rc[2]) wr_req[64] = 1'b0;
        end
        repeat (1 + gap) @(negedge clk);
    endtask

    // Scoreboard monitor: pops one expectation per response pulse.
    always @(negedge clk) begin
        logic [2:0]  v, ev;
        logic [31:0] ad;
        exp_t        x;
        if (mon_en) begin
            v = {wr_resp, rd_resp[32], if_resp[32]};
            if (v != 3'b000 || oob) begin
                vectors++;
                if (sbq.size() == 0) begin
                    miscompares++;
                    $display("FAIL stray_resp: got v=%b oob=%b at cyc %0d, want no response",
                             v, oob, cyc);
                end else begin
                    x  = sbq.pop_front();
                    ev = 3'b001 << x.ch;
                    ad = (x.ch == 0) ? if_resp[31:0] :
                         (x.ch == 1) ? rd_resp[31:0] : 32'h0;
                    if (cyc != x.cyc || v != ev || ad != x.data || oob != x.oob) begin
                        miscompares++;
                        $display("FAIL resp_ch%0d: got v=%b d=%h oob=%b cyc=%0d, want v=%b d=%h oob=%b cyc=%0d",
                                 x.ch, v, ad, oob, cyc, ev, x.data, x.oob, x.cyc);
                    end
                end
            end
            vectors++;
            if ((!if_resp[32] && if_resp[31:0] != 0) || (!rd_resp[32] && rd_resp[31:0] != 0)) begin
                miscompares++;
                $display("FAIL idle_data: got if=%h rd=%h at cyc %0d, want 0 when valid low",
                         if_resp, rd_resp, cyc);
            end
        end
    end

    task automatic check_zero(input string name, input logic [67:0] act);
        vectors++;
        if (act != 68'h0) begin
            miscompares++;
            $display("FAIL %s: got %h, want 0", name, act);
        end
    endtask

    initial begin
        int e2;
        logic [31:0] a, w;
        repeat (3) @(negedge clk);
        check_zero("reset_main", {if_resp, rd_resp, wr_resp, oob});
        check_zero("reset_lat1", {if_resp1, rd_resp1, wr_resp1, oob1});
        rstn = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        for (int i = 0; i < MW; i++)
            run_batch(3'b100, 0, 0, BASE + 32'(4 * i), $urandom, 0);

        run_batch(3'b100, 0, 0, 32'h1010, 32'hDEADBEEF, 0);
        run_batch(3'b010, 0, 32'h1012, 0, 0, 0);
        run_batch(3'b111, 32'h1000, 32'h1010, 32'h1004, 32'h12345678, 0);
        run_batch(3'b010, 0, 32'h0FFC, 0, 0, 1);
        run_batch(3'b010, 0, BASE + 32'(4 * MW), 0, 0, 0);
        run_batch(3'b100, 0, 0, BASE + 32'(4 * MW), 32'hBAD0BAD0, 0);
        run_batch(3'b001, BASE, 0, 0, 0, 0);

        a = BASE + 32'h20;
        wr_req = {1'b1, a, 32'hCAFEF00D};
        @(negedge clk);
        rstn = 1'b0;
        wr_req = '0;
        #1;
        check_zero("reset_in_wait", {if_resp, rd_resp, wr_resp, oob});
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_batch(3'b010, 0, a, 0, 0, 0);

        for (int i = 0; i < 300; i++)
            run_batch(3'($urandom_range(1, 7)), rand_addr(), rand_addr(), rand_addr(),
                      $urandom, $urandom_range(0, 2));

        repeat (LAT + 4) @(negedge clk);
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL missing_resp: got %0d pending, want 0", sbq.size());
        end

        w = 32'h00500093;
        wr_req1 = {1'b1, BASE, w};
        @(negedge clk);
        vectors++;
        if (wr_resp1 !== 1'b1) begin
            miscompares++;
            $display("FAIL lat1_wr: got %b, want 1", wr_resp1);
        end
        wr_req1 = '0;
        @(negedge clk);
        if_req1 = {1'b1, BASE};
        e2 = cyc + 1;
        for (int i = 0; i < 7; i++) begin
            logic ev;
            @(negedge clk);
            ev = ((cyc - e2) % 2) == 0;
            vectors++;
            if (if_resp1 != {ev, ev ? w : 32'h0}) begin
                miscompares++;
                $display("FAIL lat1_fetch: got %h at cyc %0d, want v=%b d=%h",
                         if_resp1, cyc, ev, ev ? w : 32'h0);
            end
        end
        if_req1 = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
